delay_sum_beamformer: RTL and testbench

- Parametrised delay-and-sum core for the PDM mic array.
- Sits between the per-mic CIC decimators and the I2S serialiser.
- Accepts one PCM frame of N_CH samples per sample strobe and applies a runtime-programmable integer delay per channel using ring buffers.
- Accumulates the unmasked channels serially, then emits one saturated, sign-extended sum per frame, with overrun and saturation flags.

---
 rtl/bf_pkg.sv | 38 +++
 rtl/bf_ring_ram.sv | 32 +++
 rtl/delay_sum_beamformer.sv | 199 +++++++++++++++++++
 tb/tb_delay_sum_beamformer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// ---------------------------------------------------------------------------
// bf_pkg
// Shared definitions for the delay-and-sum beamformer:
//   - FSM state encoding (IDLE / ACCUM / EMIT)
//   - accumulator width helper
//   - signed saturation helpers used when the output is narrower than the
//     accumulator
// ---------------------------------------------------------------------------
package bf_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;

  // Summing n_ch values of in_w bits grows by clog2(n_ch) bits at most.
  function automatic int acc_width(input int in_w, input int n_ch);
    return in_w + $clog2(n_ch);
  endfunction

  // Clamp a signed value into the signed range of an out_w-bit word.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (out_w >= 64) return v;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // True when sat_clamp would alter the value.
  function automatic logic sat_hit(input logic signed [63:0] v, input int out_w);
    return (sat_clamp(v, out_w) != v);
  endfunction

endpackage

// File: rtl/bf_ring_ram.sv
// ---------------------------------------------------------------------------
// bf_ring_ram
// One channel of sample history: DEPTH x IN_W, one synchronous write port and
// one registered read port. Contents are intentionally not reset.
//   clk      system clock
//   we       write enable
//   wr_addr  write address
//   wr_data  sample to store
//   rd_addr  read address (data appears on rd_data after the next edge)
//   rd_data  registered read data
// ---------------------------------------------------------------------------
module bf_ring_ram #(
  parameter int DEPTH = 32,
  parameter int IN_W  = 19,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [IN_W-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [IN_W-1:0] rd_data
);

  logic [IN_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/delay_sum_beamformer.sv
// ---------------------------------------------------------------------------
// delay_sum_beamformer
// Delay-and-sum core for the PDM mic array. Each sample_valid frame is written
// into per-channel ring buffers; the core then walks the channels one per
// cycle, reading each at (wp - delay) and summing the unmuted ones, and emits
// one saturated, sign-extended sum per frame.
//
// Handshake: sample_valid is a one-cycle strobe with no back-pressure. It is
// accepted only in IDLE; a strobe while busy is dropped and sets overrun.
// sum_valid is a one-cycle strobe coincident with the updated sum_out, issued
// N_CH+1 cycles after the accepted sample_valid.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   sample_valid      new frame on pcm_in
//   pcm_in            channel c at [c*IN_W +: IN_W], signed
//   delay_cfg         channel c delay at [c*DLY_W +: DLY_W]
//   mute_mask         bit c = 1 removes channel c from the sum
//   cfg_load          capture delay_cfg / mute_mask (deferred while busy)
//   clr_flags         clear overrun and sat
//   sum_out           beamformed sample, signed
//   sum_valid         one-cycle result strobe
//   busy              high in ACCUM and EMIT
//   overrun, sat      sticky status flags
//   dbg_state         current FSM state
// ---------------------------------------------------------------------------
module delay_sum_beamformer
  import bf_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int IN_W  = 19,
  parameter int DEPTH = 32,
  parameter int DLY_W = 5,
  parameter int OUT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [N_CH*IN_W-1:0]  pcm_in,
  input  logic [N_CH*DLY_W-1:0] delay_cfg,
  input  logic [N_CH-1:0]       mute_mask,
  input  logic                  cfg_load,
  input  logic                  clr_flags,
  output logic [OUT_W-1:0]      sum_out,
  output logic                  sum_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic                  sat,
  output logic [1:0]            dbg_state
);

  localparam int ACC_W  = acc_width(IN_W, N_CH);
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int FILL_W = DLY_W + 1;

  logic [1:0]              state;
  logic [DLY_W-1:0]        wp;
  logic [FILL_W-1:0]       fill;
  logic [CH_W-1:0]         ch;
  logic [CH_W-1:0]         ch_q;
  logic                    use_q;
  logic signed [ACC_W-1:0] acc;

  logic [N_CH*DLY_W-1:0]   sh_dly;
  logic [N_CH-1:0]         sh_mute;
  logic                    pend;
  logic [N_CH*DLY_W-1:0]   pend_dly;
  logic [N_CH-1:0]         pend_mute;

  logic [DLY_W-1:0]        dly_a   [N_CH];
  logic [IN_W-1:0]         rd_data [N_CH];
  logic [DLY_W-1:0]        rd_addr;
  logic                    wr_en;
  logic signed [IN_W-1:0]  sel_s;
  logic signed [ACC_W-1:0] contrib;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [63:0]      fin64;
  logic signed [63:0]      sat_val;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;
  assign wr_en     = (state == ST_IDLE) && sample_valid;

  // Ring index arithmetic wraps naturally because DEPTH == 2**DLY_W.
  assign rd_addr = wp - dly_a[ch];

  // Read data lags the issued address by one cycle, so the contribution is
  // qualified by the gate and channel index registered alongside it.
  assign sel_s    = rd_data[ch_q];
  assign contrib  = use_q ? ACC_W'(sel_s) : '0;
  assign acc_next = acc + contrib;
  assign fin64    = 64'(acc_next);
  assign sat_val  = sat_clamp(fin64, OUT_W);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign dly_a[g] = sh_dly[g*DLY_W +: DLY_W];

    bf_ring_ram #(
      .DEPTH (DEPTH),
      .IN_W  (IN_W),
      .AW    (DLY_W)
    ) u_ram (
      .clk     (clk),
      .we      (wr_en),
      .wr_addr (wp),
      .wr_data (pcm_in[g*IN_W +: IN_W]),
      .rd_addr (rd_addr),
      .rd_data (rd_data[g])
    );
  end

  // Main datapath / FSM. In ACCUM the address for channel ch is issued while
  // the data for ch-1 is accumulated; EMIT folds in the last channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      wp        <= '0;
      fill      <= '0;
      ch        <= '0;
      ch_q      <= '0;
      use_q     <= 1'b0;
      acc       <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sample_valid) begin
            fill  <= (fill == FILL_W'(DEPTH)) ? fill : fill + 1'b1;
            acc   <= '0;
            ch    <= '0;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (ch != '0) acc <= acc_next;
          if (ch == CH_W'(N_CH - 1)) state <= ST_EMIT;
          else                       ch    <= ch + 1'b1;
        end
        ST_EMIT: begin
          sum_out   <= sat_val[OUT_W-1:0];
          sum_valid <= 1'b1;
          wp        <= wp + 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // A slot whose delay reaches back past the samples written since reset
      // holds stale RAM contents and is gated to zero.
      use_q <= (state == ST_ACCUM) && !sh_mute[ch] && ({1'b0, dly_a[ch]} < fill);
      ch_q  <= ch;
    end
  end

  // Sticky flags: a new event in the same cycle as clr_flags wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
      sat     <= 1'b0;
    end else begin
      if (sample_valid && busy) overrun <= 1'b1;
      else if (clr_flags)       overrun <= 1'b0;
      if ((state == ST_EMIT) && sat_hit(fin64, OUT_W)) sat <= 1'b1;
      else if (clr_flags)                              sat <= 1'b0;
    end
  end

  // Shadow configuration. Loads during a frame are parked and applied on the
  // EMIT->IDLE edge so a frame never mixes old and new delays.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_dly    <= '0;
      sh_mute   <= '0;
      pend      <= 1'b0;
      pend_dly  <= '0;
      pend_mute <= '0;
    end else if (state == ST_IDLE) begin
      if (cfg_load) begin
        sh_dly  <= delay_cfg;
        sh_mute <= mute_mask;
      end
    end else if (state == ST_EMIT) begin
      if (cfg_load) begin
        sh_dly  <= delay_cfg;
        sh_mute <= mute_mask;
      end else if (pend) begin
        sh_dly  <= pend_dly;
        sh_mute <= pend_mute;
      end
      pend <= 1'b0;
    end else if (cfg_load) begin
      pend      <= 1'b1;
      pend_dly  <= delay_cfg;
      pend_mute <= mute_mask;
    end
  end

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// ---------------------------------------------------------------------------
// tb_delay_sum_beamformer
// Drives frames into two instances (full-width output and a 20-bit output to
// exercise clamping) and compares each result with a reference built from a
// plain history of frames: sum = sum over unmuted c of x_c[n - d_c].
// ---------------------------------------------------------------------------
module tb_delay_sum_beamformer;

  localparam int N_CH  = 8;
  localparam int IN_W  = 19;
  localparam int DEPTH = 32;
  localparam int DLY_W = 5;
  localparam int OUT_W = 32;
  localparam int SAT_W = 20;
  localparam longint SAT_HI = 524287;
  localparam longint SAT_LO = -524288;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                  sample_valid;
  logic [N_CH*IN_W-1:0]  pcm_in;
  logic [N_CH*DLY_W-1:0] delay_cfg;
  logic [N_CH-1:0]       mute_mask;
  logic                  cfg_load;
  logic                  clr_flags;
  logic [OUT_W-1:0]      sum_out;
  logic                  sum_valid, busy, overrun, sat;
  logic [1:0]            dbg_state;
  logic [SAT_W-1:0]      sum_out_s;
  logic                  sum_valid_s, busy_s, overrun_s, sat_s;
  logic [1:0]            dbg_state_s;

  delay_sum_beamformer #(.N_CH(N_CH), .IN_W(IN_W), .DEPTH(DEPTH), .DLY_W(DLY_W),
                         .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .pcm_in(pcm_in),
    .delay_cfg(delay_cfg), .mute_mask(mute_mask), .cfg_load(cfg_load),
    .clr_flags(clr_flags), .sum_out(sum_out), .sum_valid(sum_valid),
    .busy(busy), .overrun(overrun), .sat(sat), .dbg_state(dbg_state));

  delay_sum_beamformer #(.N_CH(N_CH), .IN_W(IN_W), .DEPTH(DEPTH), .DLY_W(DLY_W),
                         .OUT_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .pcm_in(pcm_in),
    .delay_cfg(delay_cfg), .mute_mask(mute_mask), .cfg_load(cfg_load),
    .clr_flags(clr_flags), .sum_out(sum_out_s), .sum_valid(sum_valid_s),
    .busy(busy_s), .overrun(overrun_s), .sat(sat_s), .dbg_state(dbg_state_s));

  // ---------------- reference model state ----------------
  logic [N_CH*IN_W-1:0] hist [$];
  logic [63:0]          exp_q [$];
  int  m_dly [N_CH];
  bit  m_mute [N_CH];
  bit  m_pend;
  int  p_dly [N_CH];
  bit  p_mute [N_CH];
  int  nd [N_CH];
  bit  nm [N_CH];
  bit  exp_sat, exp_ovr;
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag,
               $signed(got), got, $signed(exp), exp);
    end
  endtask

  function automatic longint model_sum();
    longint s = 0;
    int n = hist.size();
    for (int c = 0; c < N_CH; c++) begin
      logic [N_CH*IN_W-1:0]   f;
      logic signed [IN_W-1:0] x;
      if (!m_mute[c] && m_dly[c] <= n - 1) begin
        f = hist[n-1-m_dly[c]];
        x = f[c*IN_W +: IN_W];
        s += longint'(x);
      end
    end
    return s;
  endfunction

  function automatic logic [N_CH*IN_W-1:0] rand_frame();
    logic [N_CH*IN_W-1:0] f;
    for (int c = 0; c < N_CH; c++) f[c*IN_W +: IN_W] = IN_W'($urandom);
    return f;
  endfunction

  function automatic logic [N_CH*IN_W-1:0] ch0_frame(input int v);
    logic [N_CH*IN_W-1:0] f = rand_frame();
    f[IN_W-1:0] = IN_W'(v);
    return f;
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    for (int c = 0; c < N_CH; c++) begin
      m_dly[c] = 0; m_mute[c] = 0;
    end
    m_pend  = 0;
    exp_sat = 0;
    exp_ovr = 0;
  endtask

  task automatic drive_cfg();
    for (int c = 0; c < N_CH; c++) begin
      delay_cfg[c*DLY_W +: DLY_W] = DLY_W'(nd[c]);
      mute_mask[c] = nm[c];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic cfg_idle();
    @(negedge clk);
    drive_cfg();
    cfg_load = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      m_dly[c] = nd[c]; m_mute[c] = nm[c];
    end
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clr_flags = 1'b1;
    exp_sat = 0;
    exp_ovr = 0;
    @(negedge clk);
    clr_flags = 1'b0;
    check("sat_cleared", 64'(sat_s), 64'(0));
    check("ovr_cleared", 64'(overrun), 64'(0));
  endtask

  // One frame; ovr_at / cfg_at (cycles after acceptance, -1 = none) inject
  // a dropped strobe or a deferred config load while the frame is in flight.
  task automatic run_frame(input logic [N_CH*IN_W-1:0] f, input int ovr_at,
                           input int cfg_at);
    int e;
    int busy_cnt;
    @(negedge clk);
    hist.push_back(f);
    if (hist.size() > DEPTH) void'(hist.pop_front());
    exp_q.push_back(64'(model_sum()));
    pcm_in       = f;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    e = 0;
    busy_cnt = 0;
    while (!sum_valid && e < 20) begin
      if (busy) busy_cnt++;
      sample_valid = (e == ovr_at);
      if (e == ovr_at) begin
        pcm_in  = rand_frame();
        exp_ovr = 1;
      end
      if (e == cfg_at) begin
        drive_cfg();
        cfg_load = 1'b1;
        m_pend = 1;
        for (int c = 0; c < N_CH; c++) begin
          p_dly[c] = nd[c]; p_mute[c] = nm[c];
        end
      end else begin
        cfg_load = 1'b0;
      end
      @(negedge clk);
      e++;
    end
    sample_valid = 1'b0;
    cfg_load     = 1'b0;
    check("latency", 64'(e), 64'(9));
    check("busy_cycles", 64'(busy_cnt), 64'(9));
    check("busy_after", 64'(busy), 64'(0));
    check("overrun", 64'(overrun), 64'(exp_ovr));
    if (m_pend) begin
      for (int c = 0; c < N_CH; c++) begin
        m_dly[c] = p_dly[c]; m_mute[c] = p_mute[c];
      end
      m_pend = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    longint ex;
    longint cl;
    if (rst && sum_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_sum_valid", 64'(1), 64'(0));
      end else begin
        ex = longint'(exp_q.pop_front());
        cl = (ex > SAT_HI) ? SAT_HI : ((ex < SAT_LO) ? SAT_LO : ex);
        if (cl != ex) exp_sat = 1;
        check("sum_out", 64'($signed(sum_out)), 64'(ex));
        check("sum_out_narrow", 64'($signed(sum_out_s)), 64'(cl));
        check("sat_narrow", 64'(sat_s), 64'(exp_sat));
        check("sat_wide", 64'(sat), 64'(0));
        check("sum_valid_pair", 64'(sum_valid_s), 64'(1));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    sample_valid = 1'b0;
    pcm_in = '0;
    delay_cfg = '0;
    mute_mask = '0;
    cfg_load = 1'b0;
    clr_flags = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      nd[c] = 0; nm[c] = 0;
    end
    model_reset();
    do_reset();

    check("rst_sum_out", 64'(sum_out), 64'(0));
    check("rst_sum_valid", 64'(sum_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    check("rst_sat", 64'(sat), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));

    // All channels 100, no delay, no mutes.
    run_frame({N_CH{19'd100}}, -1, -1);
    check("all100_sum", 64'(sum_out), 64'(800));

    // Channel 0 delay 3, rest muted: fill gating before the 4th frame.
    do_reset();
    nd[0] = 3;
    for (int c = 1; c < N_CH; c++) nm[c] = 1;
    cfg_idle();
    for (int k = 1; k <= 5; k++) begin
      run_frame(ch0_frame(k), -1, -1);
      check("dly3_sum", 64'(sum_out), 64'((k >= 4) ? k - 3 : 0));
    end

    // Maximum delay across the ring wrap.
    do_reset();
    nd[0] = DEPTH - 1;
    cfg_idle();
    for (int k = 0; k < 40; k++) begin
      run_frame(ch0_frame(k), -1, -1);
      check("dly31_sum", 64'(sum_out), 64'((k >= DEPTH - 1) ? k - (DEPTH - 1) : 0));
    end

    // Saturation on the narrow instance, then flag clear.
    for (int c = 0; c < N_CH; c++) begin
      nd[c] = 0; nm[c] = 0;
    end
    cfg_idle();
    run_frame({N_CH{19'h3FFFF}}, -1, -1);
    check("sat_value", 64'(sum_out_s), 64'(20'h7FFFF));
    check("sat_set", 64'(sat_s), 64'(1));
    check("wide_value", 64'(sum_out), 64'(N_CH * 262143));
    clear_flags();

    // Overrun: strobe 3 cycles after acceptance is dropped.
    run_frame(rand_frame(), 2, -1);
    for (int c = 0; c < N_CH; c++) nd[c] = 1;
    cfg_idle();
    run_frame(rand_frame(), -1, -1);
    clear_flags();

    // Config load mid-frame: channel 1 delay 0 -> 2 applies to the next frame.
    for (int c = 0; c < N_CH; c++) nd[c] = 0;
    cfg_idle();
    nd[1] = 2;
    run_frame(rand_frame(), -1, 3);
    run_frame(rand_frame(), -1, -1);
    run_frame(rand_frame(), -1, -1);

    // Reset during ACCUM: outputs drop at once, no result follows.
    @(negedge clk);
    pcm_in = rand_frame();
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_sum_out", 64'(sum_out), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_sum_valid", 64'(sum_valid), 64'(0));
    check("arst_overrun", 64'(overrun), 64'(0));
    check("arst_sat", 64'(sat_s), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    check("arst_idle", 64'(busy), 64'(0));

    // Randomized frames, configurations, dropped strobes and flag clears.
    for (int i = 0; i < 60; i++) begin
      int ovr_at;
      int cfg_at;
      if ($urandom_range(0, 3) == 0) begin
        for (int c = 0; c < N_CH; c++) begin
          nd[c] = $urandom_range(0, DEPTH - 1);
          nm[c] = ($urandom_range(0, 3) == 0);
        end
        cfg_idle();
      end
      ovr_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 8) : -1;
      cfg_at = -1;
      if ($urandom_range(0, 4) == 0) begin
        cfg_at = $urandom_range(0, 8);
        for (int c = 0; c < N_CH; c++) begin
          nd[c] = $urandom_range(0, DEPTH - 1);
          nm[c] = ($urandom_range(0, 3) == 0);
        end
      end
      run_frame(rand_frame(), ovr_at, cfg_at);
      if ($urandom_range(0, 7) == 0) clear_flags();
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
